// File: rtl/i2c_pkg.sv
// Shared types for the I2C write-only target: FSM states, byte width and the
// synchronised view of the two bus lines.
package i2c_pkg;

    localparam int I2C_BITS_PER_BYTE = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } tgt_state_t;

    typedef struct packed {
        logic sda;
        logic scl;
        logic sda_prev;
        logic scl_prev;
    } line_state_t;

endpackage

// File: rtl/i2c_target_rx_if.sv
// Pin, consumer and debug signals of the I2C write-only target.
// Handshake: o_valid pulses one cycle with o_data; i_ready is sampled only at the
// SCL fall after the 8th data bit and selects ACK (byte delivered) or NACK (byte dropped).
interface i2c_target_rx_if;
    import i2c_pkg::*;

    logic        i_sda;
    logic        i_scl;
    logic        i_ready;
    logic        o_sda_drive;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_start;
    logic        o_stop;
    logic        o_busy;
    tgt_state_t  dbg_state;
    line_state_t dbg_line;

    modport slave (
        input  i_sda, i_scl, i_ready,
        output o_sda_drive, o_data, o_valid, o_start, o_stop, o_busy,
        output dbg_state, dbg_line
    );

    modport master (
        output i_sda, i_scl, i_ready,
        input  o_sda_drive, o_data, o_valid, o_start, o_stop, o_busy,
        input  dbg_state, dbg_line
    );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchroniser chain plus previous-value register for one open-drain line.
// Flops reset to 1 so a released (pulled-up) bus never looks like an edge.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2  // must be at least 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic synced,
    output logic prev,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign prev   = prev_q;
    assign rise   = synced & ~prev_q;
    assign fall   = ~synced & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: decodes START/STOP, matches its 7-bit address with R/W=0
// and delivers received bytes, ACKing each one only when the consumer is ready.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input logic            i_clk,
    input logic            i_rst_n,
    i2c_target_rx_if.slave bus
);

    localparam logic [3:0] BYTE_BITS = 4'(I2C_BITS_PER_BYTE);

    line_state_t line;
    logic        sda_rise, sda_fall, scl_rise, scl_fall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .line   (bus.i_sda),
        .synced (line.sda),
        .prev   (line.sda_prev),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .line   (bus.i_scl),
        .synced (line.scl),
        .prev   (line.scl_prev),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    // SCL must be high on both samples so an SDA change at an SCL edge is not a condition
    logic start_cond, stop_cond;
    assign start_cond = sda_fall & line.scl & line.scl_prev;
    assign stop_cond  = sda_rise & line.scl & line.scl_prev;

    tgt_state_t state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       sda_drive_q, sda_drive_d;
    logic       valid_q, valid_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       busy_q, busy_d;
    logic       byte_full, addr_match;

    assign byte_full  = (bit_cnt_q == BYTE_BITS);
    assign addr_match = (shift_q[7:1] == TARGET_ADDR) && !shift_q[0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            sda_drive_q <= 1'b1;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            sda_drive_q <= sda_drive_d;
            valid_q     <= valid_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        sda_drive_d = sda_drive_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        start_d     = 1'b0;
        stop_d      = 1'b0;

        if (start_cond) begin
            state_d     = ADDR;
            bit_cnt_d   = '0;
            shift_d     = '0;
            sda_drive_d = 1'b1;
            start_d     = 1'b1;
            busy_d      = 1'b1;
        end else if (stop_cond) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            sda_drive_d = 1'b1;
            stop_d      = 1'b1;
            busy_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR, DATA: begin
                    if (scl_rise && !byte_full) begin
                        shift_d   = {shift_q[6:0], line.sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && byte_full) begin
                        if (state_q == ADDR) begin
                            state_d     = addr_match ? ADDR_ACK : IGNORE;
                            sda_drive_d = !addr_match;
                        end else if (bus.i_ready) begin
                            state_d     = DATA_ACK;
                            data_d      = shift_q;
                            valid_d     = 1'b1;
                            sda_drive_d = 1'b0;
                        end else begin
                            state_d     = IGNORE;
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // ACK is held through the 9th clock and released on its falling edge
                    if (scl_fall) begin
                        state_d     = DATA;
                        bit_cnt_d   = '0;
                        sda_drive_d = 1'b1;
                    end
                end
                IGNORE: sda_drive_d = 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.o_sda_drive = sda_drive_q;
    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_start     = start_q;
    assign bus.o_stop      = stop_q;
    assign bus.o_busy      = busy_q;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_line    = line;

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- Write-only I2C target (responder) for the on-chip bus: the other end of our I2C master (start/stop gen, bit engine).
- Watches SDA/SCL and detects START, repeated START and STOP.
- Shifts in the address byte and ACKs only its own 7-bit address with R/W=0.
- Receives data bytes, presents each on a valid strobe, and ACKs or NACKs per byte using a ready input.
- Used for loopback verification of the master and as a register-write port for an FPGA-side peripheral.

Parameters:
- TARGET_ADDR, 7'h42, 7-bit address this target answers to.
- SYNC_STAGES, 2, flops in each SDA/SCL input synchroniser (minimum 2).

Ports:
- i_clk  in  1  system clock; all logic is on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sda  in  1  SDA pin level (open-drain, pulled up).
- i_scl  in  1  SCL pin level.
- i_ready  in  1  consumer can accept a byte; sampled at the ACK decision point.
- o_sda_drive  out  1  1 = release SDA (high-Z), 0 = pull SDA low.
- o_data  out  8  last received data byte, MSB first on the wire.
- o_valid  out  1  one-cycle pulse; o_data is valid on the same cycle.
- o_start  out  1  one-cycle pulse on START or repeated START.
- o_stop  out  1  one-cycle pulse on STOP.
- o_busy  out  1  high from START until STOP.

Behaviour:
- Reset values: o_sda_drive=1, o_data=0, o_valid=0, o_start=0, o_stop=0, o_busy=0, state IDLE, bit count 0, synchroniser flops all 1.
- Reset is asynchronous and may be asserted mid-transfer. The target releases SDA immediately and returns to IDLE.
- Input path:
  - SDA and SCL each pass through SYNC_STAGES flops, then one "previous" register.
  - Edges and conditions are decoded from synced vs previous values.
  - A bus event is therefore visible SYNC_STAGES+1 i_clk cycles after the pin change.
- Condition decode, in priority order:
  - START: SDA falls while SCL is high (both synced and previous).
  - STOP: SDA rises while SCL is high.
  - SCL rise: sample a bit.
  - SCL fall: advance the drive phase.
- START and STOP override any state and any bit in progress.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE:
  - START -> ADDR; clear bit count and shift register; o_start pulse; o_busy=1.
  - SCL edges are ignored.
- ADDR:
  - On each SCL rise, shift SDA into the LSB and increment the bit count.
  - On the SCL fall after the 8th bit, compare: byte[7:1]==TARGET_ADDR and byte[0]==0.
  - Match -> ADDR_ACK and set o_sda_drive=0 on that same cycle.
  - No match or R/W=1 -> IGNORE with SDA released (NACK).
- ADDR_ACK: on the next SCL fall (end of the 9th clock), set o_sda_drive=1, clear the bit count, go to DATA.
- DATA:
  - Shift as in ADDR.
  - At the SCL fall after the 8th bit with i_ready=1: o_data=byte, o_valid pulse, o_sda_drive=0, go to DATA_ACK.
  - At that point with i_ready=0: NACK (SDA released), no o_valid, go to IGNORE.
- DATA_ACK: on the next SCL fall, release SDA, clear the bit count, go to DATA.
- IGNORE: SDA stays released; wait for START (-> ADDR) or STOP (-> IDLE).
- STOP from any non-IDLE state:
  - Go to IDLE, o_stop pulse, o_busy=0, SDA released.
  - STOP in IDLE: o_stop pulses, o_busy stays 0.
- Repeated START in any state: same as START, including releasing SDA if it is held. A partial byte is discarded with no o_valid.
- SDA is changed only on detected SCL falls or on reset/condition events, never while SCL is high. The target's own ACK edges therefore never decode as START/STOP.
- The bit counter is 4 bits wide and saturates at 8. Extra SCL rises beyond 8 without a fall are ignored.
- No clock stretching: SCL is never driven.

Decomposition:
- Package i2c_pkg holds:
  - typedef enum tgt_state_t {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE}
  - I2C_BITS_PER_BYTE=8
  - typedef struct for synced line state (sda, scl, sda_prev, scl_prev).
- Sub-module i2c_line_sync: parameterised synchroniser plus previous-value register for one line. Instantiate it twice; it also provides rise/fall flags.

Test Plan:
- Master writes addr 0x42/W plus data 0xA5, i_ready=1 -> o_start pulse; SDA pulled low during both 9th clocks; o_valid once with o_data=0xA5; STOP gives o_stop pulse and o_busy 1->0.
- Address 0x43/W -> SDA never pulled low; no o_valid; state IGNORE until STOP, then IDLE.
- Address 0x42 with R/W=1 -> NACK (SDA high on 9th clock); no o_valid.
- Two data bytes 0x01, 0xFE; i_ready=0 on the second -> first byte ACKed and o_valid with 0x01; second byte NACKed with no o_valid; target ignores until STOP.
- Repeated START after 4 data bits, then addr 0x42/W plus 0x3C -> second o_start pulse; partial byte dropped; o_valid once with 0x3C; o_busy stays 1 throughout.
- i_rst_n low while ACK holds SDA low -> o_sda_drive=1 asynchronously, o_busy=0; after reset release the next START is detected normally.
